// File: rtl/game_defs_pkg.sv
// Shared game definitions: FSM state encodings and playfield constants.
package game_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_COOLDOWN  = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // Bottom playfield row; the collision block raises health_update here.
    localparam int unsigned BOTTOM_Y = 119;

endpackage

// File: rtl/rise_detect.sv
// Level-to-event converter: registers the level and flags a 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o     // combinational: level_i & ~previous level
);

    logic level_q;

    // Delay the level by one cycle so a rising transition can be spotted.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/health_tracker.sv
// Player health tracker: turns collision levels into single hits, applies a
// post-hit invulnerability window and tracks the game-over condition.
module health_tracker
    import game_defs::*;
#(
    parameter int unsigned MAX_HEALTH      = 3,
    parameter int unsigned HEALTH_W        = 2,
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                health_update,
    output logic [HEALTH_W-1:0] health,
    output logic                hit_pulse,
    output logic                invuln,
    output logic                game_over,
    output logic                playing
);

    state_t              state_q;
    logic [HEALTH_W-1:0] health_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hit_pulse_q;
    logic                invuln_q;
    logic                game_over_q;
    logic                playing_q;
    logic                hit_evt;

    // A collision level that stays high must cost only one health point.
    rise_detect u_rise_detect (
        .clk     (clk),
        .rst     (rst),
        .level_i (health_update),
        .rise_o  (hit_evt)
    );

    // Game FSM with registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            health_q    <= HEALTH_W'(MAX_HEALTH);
            cnt_q       <= '0;
            hit_pulse_q <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    health_q <= HEALTH_W'(MAX_HEALTH);
                    if (start) begin
                        state_q   <= ST_PLAY;
                        playing_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (hit_evt && (health_q != '0)) begin
                        hit_pulse_q <= 1'b1;
                        health_q    <= health_q - HEALTH_W'(1);
                        if (health_q == HEALTH_W'(1)) begin
                            state_q     <= ST_GAME_OVER;
                            game_over_q <= 1'b1;
                            playing_q   <= 1'b0;
                        end else begin
                            state_q  <= ST_COOLDOWN;
                            cnt_q    <= CNT_W'(COOLDOWN_CYCLES - 1);
                            invuln_q <= 1'b1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // Hits arriving here are dropped, not queued.
                    if (cnt_q == '0) begin
                        state_q  <= ST_PLAY;
                        invuln_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_GAME_OVER: begin
                    health_q <= '0;
                    if (start) begin
                        state_q     <= ST_PLAY;
                        health_q    <= HEALTH_W'(MAX_HEALTH);
                        game_over_q <= 1'b0;
                        playing_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    health_q    <= HEALTH_W'(MAX_HEALTH);
                    cnt_q       <= '0;
                    invuln_q    <= 1'b0;
                    game_over_q <= 1'b0;
                    playing_q   <= 1'b0;
                end
            endcase
        end
    end

    assign health    = health_q;
    assign hit_pulse = hit_pulse_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_health_tracker.sv
// Scoreboard bench for health_tracker (MAX_HEALTH=3, COOLDOWN_CYCLES=4).
module tb_health_tracker;

    typedef struct {
        int         idx;
        logic [1:0] health;
        logic       hit_pulse;
        logic       invuln;
        logic       game_over;
        logic       playing;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       health_update;
    logic [1:0] health;
    logic       hit_pulse;
    logic       invuln;
    logic       game_over;
    logic       playing;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   n_push;

    health_tracker #(
        .MAX_HEALTH      (3),
        .HEALTH_W        (2),
        .COOLDOWN_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .health_update (health_update),
        .health        (health),
        .hit_pulse     (hit_pulse),
        .invuln        (invuln),
        .game_over     (game_over),
        .playing       (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic v(input logic r, input logic s, input logic hu,
                     input logic [1:0] h, input logic hp, input logic inv,
                     input logic go, input logic pl);
        exp_t e;
        @(negedge clk);
        rst           = r;
        start         = s;
        health_update = hu;
        e.idx       = n_push;
        e.health    = h;
        e.hit_pulse = hp;
        e.invuln    = inv;
        e.game_over = go;
        e.playing   = pl;
        exp_q.push_back(e);
        n_push++;
    endtask

    // Monitor: after each active edge, compare DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (health !== e.health || hit_pulse !== e.hit_pulse ||
                    invuln !== e.invuln || game_over !== e.game_over ||
                    playing !== e.playing) begin
                    n_err++;
                    $display("FAIL vec%0d: got health=%0d hit=%b inv=%b go=%b play=%b, want health=%0d hit=%b inv=%b go=%b play=%b",
                             e.idx, health, hit_pulse, invuln, game_over, playing,
                             e.health, e.hit_pulse, e.invuln, e.game_over, e.playing);
                end
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; n_push = 0;
        rst = 1'b1; start = 1'b0; health_update = 1'b0;

        // Reset and start
        v(1,0,0, 3,0,0,0,0);
        v(1,0,0, 3,0,0,0,0);
        v(0,0,0, 3,0,0,0,0);
        v(0,1,0, 3,0,0,0,1);

        // Level held for 10 cycles: one hit, invuln for exactly 4 cycles
        v(0,0,1, 2,1,1,0,1);
        v(0,0,1, 2,0,1,0,1);
        v(0,0,1, 2,0,1,0,1);
        v(0,0,1, 2,0,1,0,1);
        v(0,0,1, 2,0,0,0,1);
        for (int i = 0; i < 5; i++) v(0,0,1, 2,0,0,0,1);
        v(0,0,0, 2,0,0,0,1);

        // Cooldown drop, then a hit in the first PLAY cycle after cooldown
        v(1,0,0, 3,0,0,0,0);
        v(0,1,0, 3,0,0,0,1);
        v(0,0,1, 2,1,1,0,1);
        v(0,0,0, 2,0,1,0,1);
        v(0,0,1, 2,0,1,0,1);
        v(0,0,0, 2,0,1,0,1);
        v(0,0,0, 2,0,0,0,1);
        v(0,0,1, 1,1,1,0,1);
        v(0,1,0, 1,0,1,0,1);
        v(0,0,0, 1,0,1,0,1);
        v(0,0,0, 1,0,1,0,1);
        v(0,0,0, 1,0,0,0,1);
        v(0,0,1, 0,1,0,1,0);
        v(0,0,0, 0,0,0,1,0);
        v(0,0,1, 0,0,0,1,0);
        v(0,0,0, 0,0,0,1,0);
        v(0,1,0, 3,0,0,0,1);

        // Three spaced hits to game over, further hits ignored
        v(0,0,1, 2,1,1,0,1);
        v(0,0,0, 2,0,1,0,1);
        v(0,0,0, 2,0,1,0,1);
        v(0,0,0, 2,0,1,0,1);
        v(0,0,0, 2,0,0,0,1);
        v(0,0,1, 1,1,1,0,1);
        v(0,0,0, 1,0,1,0,1);
        v(0,0,0, 1,0,1,0,1);
        v(0,0,0, 1,0,1,0,1);
        v(0,0,0, 1,0,0,0,1);
        v(0,0,1, 0,1,0,1,0);
        v(0,0,1, 0,0,0,1,0);
        v(0,0,0, 0,0,0,1,0);
        v(0,0,1, 0,0,0,1,0);

        // Restart from game over, start ignored in PLAY
        v(0,1,0, 3,0,0,0,1);
        v(0,1,0, 3,0,0,0,1);

        // start beats a simultaneous rising edge in IDLE; held level gives no hit
        v(1,0,0, 3,0,0,0,0);
        v(0,1,1, 3,0,0,0,1);
        v(0,0,1, 3,0,0,0,1);
        v(0,0,0, 3,0,0,0,1);

        // Reset in the middle of cooldown (counter at 2)
        v(0,0,1, 2,1,1,0,1);
        v(0,0,0, 2,0,1,0,1);
        v(1,0,0, 3,0,0,0,0);
        v(0,0,1, 3,0,0,0,0);
        v(0,0,0, 3,0,0,0,0);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
